// File: rtl/matrix_engine.sv
// N x N signed matrix unit driven by a single enter button: loads A then B, computes add,
// subtract, multiply or transpose serially with saturation, and steps the result out per press.
module matrix_engine #(
    parameter int unsigned N  = 2,
    parameter int unsigned DW = 8,
    parameter int unsigned OW = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [DW-1:0]             data_in,
    input  logic                      enter,
    input  logic [1:0]                op,
    output logic [OW-1:0]             data_out,
    output logic [$clog2(N*N)-1:0]    index,
    output logic                      finish,
    output logic                      error,
    output logic                      busy
);

    localparam int unsigned NN = N * N;
    localparam int unsigned IW = $clog2(NN);
    localparam int unsigned AW = 2 * DW + $clog2(N) + 1;

    localparam logic [IW-1:0] NIdx    = IW'(N);
    localparam logic [IW-1:0] LastRc  = IW'(N - 1);
    localparam logic [IW-1:0] LastIdx = IW'(NN - 1);

    localparam logic signed [AW-1:0] SatMax = {{(AW - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [AW-1:0] SatMin = {{(AW - OW + 1){1'b1}}, {(OW - 1){1'b0}}};

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpSub = 2'b01;
    localparam logic [1:0] OpMul = 2'b10;
    localparam logic [1:0] OpTrn = 2'b11;

    typedef enum logic [2:0] {StIdle, StLoadA, StLoadB, StCompute, StShow} state_e;

    state_e               state_q;
    logic                 enter_q;
    logic [1:0]           op_q;
    logic [IW-1:0]        i_q, j_q, k_q;
    logic signed [AW-1:0] acc_q;
    logic [DW-1:0]        mat_a [NN];
    logic [DW-1:0]        mat_b [NN];
    logic [OW-1:0]        mat_c [NN];

    logic                 rise;
    logic [IW-1:0]        a_idx, b_idx, c_idx;
    logic [DW-1:0]        elem_a, elem_b;
    logic signed [AW-1:0] ext_a, ext_b, prod, sum;
    logic [OW-1:0]        sat_val;
    logic                 sat_hit, step_write, step_last;

    // One datapath step: operand select, exact arithmetic, then clamp to the output range.
    always_comb begin
        rise  = enter & ~enter_q;
        c_idx = i_q * NIdx + j_q;
        a_idx = c_idx;
        b_idx = c_idx;
        if (op_q == OpMul) begin
            a_idx = i_q * NIdx + k_q;
            b_idx = k_q * NIdx + j_q;
        end else if (op_q == OpTrn) begin
            a_idx = j_q * NIdx + i_q;
        end
        elem_a = mat_a[a_idx];
        elem_b = mat_b[b_idx];
        ext_a  = {{(AW - DW){elem_a[DW-1]}}, elem_a};
        ext_b  = {{(AW - DW){elem_b[DW-1]}}, elem_b};
        prod   = ext_a * ext_b;
        case (op_q)
            OpAdd:   sum = ext_a + ext_b;
            OpSub:   sum = ext_a - ext_b;
            OpMul:   sum = ((k_q == '0) ? '0 : acc_q) + prod;
            default: sum = ext_a;
        endcase
        sat_hit = 1'b1;
        if (sum > SatMax) begin
            sat_val = SatMax[OW-1:0];
        end else if (sum < SatMin) begin
            sat_val = SatMin[OW-1:0];
        end else begin
            sat_val = sum[OW-1:0];
            sat_hit = 1'b0;
        end
        step_write = (op_q != OpMul) || (k_q == LastRc);
        step_last  = step_write && (i_q == LastRc) && (j_q == LastRc);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            enter_q  <= 1'b1;
            op_q     <= OpAdd;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            data_out <= '0;
            index    <= '0;
            finish   <= 1'b0;
            error    <= 1'b0;
            busy     <= 1'b0;
            for (int n = 0; n < NN; n++) begin
                mat_a[n] <= '0;
                mat_b[n] <= '0;
                mat_c[n] <= '0;
            end
        end else begin
            enter_q <= enter;
            case (state_q)
                StIdle: begin
                    if (rise) begin
                        op_q     <= op;
                        error    <= 1'b0;
                        mat_a[0] <= data_in;
                        index    <= IW'(1);
                        state_q  <= StLoadA;
                    end
                end
                StLoadA: begin
                    if (rise) begin
                        mat_a[index] <= data_in;
                        if (index == LastIdx) begin
                            index <= '0;
                            i_q   <= '0;
                            j_q   <= '0;
                            k_q   <= '0;
                            if (op_q == OpTrn) begin
                                state_q <= StCompute;
                                busy    <= 1'b1;
                            end else begin
                                state_q <= StLoadB;
                            end
                        end else begin
                            index <= index + IW'(1);
                        end
                    end
                end
                StLoadB: begin
                    if (rise) begin
                        mat_b[index] <= data_in;
                        if (index == LastIdx) begin
                            index   <= '0;
                            i_q     <= '0;
                            j_q     <= '0;
                            k_q     <= '0;
                            state_q <= StCompute;
                            busy    <= 1'b1;
                        end else begin
                            index <= index + IW'(1);
                        end
                    end
                end
                StCompute: begin
                    acc_q <= sum;
                    if (step_write) begin
                        mat_c[c_idx] <= sat_val;
                        if (sat_hit) begin
                            error <= 1'b1;
                        end
                    end
                    // k innermost for multiply; elementwise ops walk (i, j) directly.
                    if (op_q == OpMul && k_q != LastRc) begin
                        k_q <= k_q + IW'(1);
                    end else begin
                        k_q <= '0;
                        if (j_q == LastRc) begin
                            j_q <= '0;
                            i_q <= i_q + IW'(1);
                        end else begin
                            j_q <= j_q + IW'(1);
                        end
                    end
                    // C[0] was written on an earlier step, so it is already valid here.
                    if (step_last) begin
                        state_q  <= StShow;
                        busy     <= 1'b0;
                        finish   <= 1'b1;
                        index    <= '0;
                        data_out <= mat_c[0];
                    end
                end
                StShow: begin
                    if (rise) begin
                        if (index == LastIdx) begin
                            state_q  <= StIdle;
                            index    <= '0;
                            finish   <= 1'b0;
                            data_out <= '0;
                        end else begin
                            index    <= index + IW'(1);
                            data_out <= mat_c[index + IW'(1)];
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_engine.sv
// Directed bench for matrix_engine (N=2, DW=8, OW=16): table of whole jobs with hand-computed
// results, plus a reset-during-load sequence with enter held high.
module tb_matrix_engine;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  data_in = '0;
    logic        enter = 1'b0;
    logic [1:0]  op = '0;
    logic [15:0] data_out;
    logic [1:0]  index;
    logic        finish, error, busy;

    int n_vec = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    matrix_engine #(.N(2), .DW(8), .OW(16)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .data_in  (data_in),
        .enter    (enter),
        .op       (op),
        .data_out (data_out),
        .index    (index),
        .finish   (finish),
        .error    (error),
        .busy     (busy)
    );

    typedef struct {
        logic [1:0]       op;
        logic [3:0][7:0]  a;
        logic [3:0][7:0]  b;
        logic [3:0][15:0] c;
        logic             err;
        int               cyc;
    } vec_t;

    vec_t vecs [5];
    vec_t v_rst;

    function automatic vec_t mk(input logic [1:0] o, input int a0, a1, a2, a3,
                                input int b0, b1, b2, b3, input int c0, c1, c2, c3,
                                input logic e, input int cyc);
        vec_t v;
        v.op   = o;
        v.a[0] = 8'(a0); v.a[1] = 8'(a1); v.a[2] = 8'(a2); v.a[3] = 8'(a3);
        v.b[0] = 8'(b0); v.b[1] = 8'(b1); v.b[2] = 8'(b2); v.b[3] = 8'(b3);
        v.c[0] = 16'(c0); v.c[1] = 16'(c1); v.c[2] = 16'(c2); v.c[3] = 16'(c3);
        v.err  = e;
        v.cyc  = cyc;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic press(input logic [7:0] val);
        @(negedge clock);
        data_in = val;
        enter   = 1'b1;
        @(negedge clock);
        enter = 1'b0;
        @(negedge clock);
    endtask

    task automatic run_job(input vec_t v);
        logic [7:0] vals [8];
        int total;
        int cnt;
        for (int e = 0; e < 4; e++) begin
            vals[e]     = v.a[e];
            vals[e + 4] = v.b[e];
        end
        total = (v.op == 2'b11) ? 4 : 8;
        op = v.op;
        press(vals[0]);
        check("first press index", int'(index), 1);
        check("first press error", int'(error), 0);
        op = ~v.op;
        for (int e = 1; e < total - 1; e++) press(vals[e]);
        // Last operand: count busy cycles; re-press so a rise lands on the final compute edge.
        @(negedge clock);
        data_in = vals[total - 1];
        enter   = 1'b1;
        @(negedge clock);
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            enter = (cnt == v.cyc);
            @(negedge clock);
        end
        enter = 1'b0;
        check("busy cycles", cnt, v.cyc);
        check("busy low in show", int'(busy), 0);
        for (int e = 0; e < 4; e++) begin
            check("data_out", int'($signed(data_out)), int'($signed(v.c[e])));
            check("show index", int'(index), e);
            check("show finish", int'(finish), 1);
            check("show error", int'(error), int'(v.err));
            press(8'h55);
        end
        check("exit finish", int'(finish), 0);
        check("exit index", int'(index), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = mk(2'b00, 1, 2, 3, 4, 10, 20, 30, 40, 11, 22, 33, 44, 1'b0, 4);
        vecs[1] = mk(2'b01, -128, 0, 5, -1, 1, -128, 5, 127, -129, 128, 0, -128, 1'b0, 4);
        vecs[2] = mk(2'b10, 1, 2, 3, 4, 5, 6, 7, 8, 19, 22, 43, 50, 1'b0, 8);
        vecs[3] = mk(2'b10, -128, -128, 0, 0, -128, 0, -128, 0, 32767, 0, 0, 0, 1'b1, 8);
        vecs[4] = mk(2'b11, 1, 2, 3, 4, 0, 0, 0, 0, 1, 3, 2, 4, 1'b0, 4);
        v_rst   = mk(2'b11, 7, 1, 2, 3, 0, 0, 0, 0, 7, 2, 1, 3, 1'b0, 4);

        repeat (2) @(negedge clock);
        check("reset data_out", int'(data_out), 0);
        check("reset index", int'(index), 0);
        check("reset finish", int'(finish), 0);
        check("reset error", int'(error), 0);
        check("reset busy", int'(busy), 0);
        reset_n = 1'b1;
        @(negedge clock);

        for (int t = 0; t < 5; t++) run_job(vecs[t]);

        // Reset in LOAD_B with enter held high.
        op = 2'b00;
        press(8'd1); press(8'd2); press(8'd3); press(8'd4); press(8'd5);
        @(negedge clock);
        data_in = 8'd6;
        enter   = 1'b1;
        @(negedge clock);
        check("load_b index", int'(index), 2);
        #2 reset_n = 1'b0;
        #1;
        check("async reset data_out", int'(data_out), 0);
        check("async reset index", int'(index), 0);
        check("async reset finish", int'(finish), 0);
        check("async reset busy", int'(busy), 0);
        check("async reset error", int'(error), 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("held enter no load", int'(index), 0);
        enter = 1'b0;
        run_job(v_rst);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
